// File: rtl/iso7816_pkg.sv
// Shared definitions for the ISO7816 exchange sequencer: state encoding and default widths.
package iso7816_pkg;

  localparam int DEFAULT_WT_WIDTH    = 24;
  localparam int DEFAULT_GUARD_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_LOAD  = 3'd1,
    ST_TX_RUN   = 3'd2,
    ST_TX_GUARD = 3'd3,
    ST_RX_WAIT  = 3'd4,
    ST_RX_ACK   = 3'd5,
    ST_DONE     = 3'd6
  } seqState_t;

endpackage

// File: rtl/iso7816_down_counter.sv
// Loadable down counter that stops at zero; used for guard time and waiting time.
module iso7816_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // load wins over enable so a reload and a count in the same cycle keep the reload value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/iso7816_exchange_sequencer.sv
// Sequences one half-duplex ISO7816 exchange: guarded byte transmission, line turnaround,
// then reception under a waiting-time limit.
module iso7816_exchange_sequencer
  import iso7816_pkg::*;
#(
  parameter int WT_WIDTH    = DEFAULT_WT_WIDTH,
  parameter int GUARD_WIDTH = DEFAULT_GUARD_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmdStart,
  input  logic [7:0]             cmdTxLen,
  input  logic [7:0]             cmdRxLen,
  input  logic [GUARD_WIDTH-1:0] guardCycles,
  input  logic [WT_WIDTH-1:0]    waitCycles,
  input  logic [7:0]             txByte,
  input  logic                   txByteValid,
  output logic                   txByteReady,
  output logic [7:0]             rxByte,
  output logic                   rxByteValid,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   charError,
  output logic [7:0]             uartTxData,
  output logic                   uartStartTx,
  output logic                   uartAckFlags,
  input  logic                   uartTxRun,
  input  logic                   uartTxFull,
  input  logic [7:0]             uartRxData,
  input  logic                   uartRxReady,
  input  logic                   uartFrameErr,
  input  logic                   uartOverrun,
  input  logic                   uartRxStart
);

  seqState_t state, nextState;

  logic [7:0]             txLeft, rxLeft;
  logic [GUARD_WIDTH-1:0] guardLatched;
  logic [WT_WIDTH-1:0]    waitLatched;
  logic [7:0]             txDataReg, rxByteReg;
  logic                   startTxReg, timeoutReg, charErrorReg, txRunPrev;

  logic                   guardLoad, guardZero;
  logic [GUARD_WIDTH-1:0] guardCount;
  logic                   waitLoad, waitZero;
  logic [WT_WIDTH-1:0]    waitLoadValue, waitCount;

  logic txFire, txFall, rxEvent, timeoutHit;

  assign rxEvent    = uartRxReady | uartFrameErr | uartOverrun;
  assign txFire     = (state == ST_TX_LOAD) & txByteValid & ~uartTxFull & ~uartTxRun;
  assign txFall     = txRunPrev & ~uartTxRun;
  // an rx event or a start bit in the expiry cycle both beat the timeout
  assign timeoutHit = (state == ST_RX_WAIT) & ~rxEvent & ~uartRxStart & waitZero;

  always_comb begin
    nextState     = state;
    guardLoad     = 1'b0;
    waitLoad      = 1'b0;
    waitLoadValue = waitLatched;
    case (state)
      ST_IDLE: begin
        if (cmdStart) begin
          if (cmdTxLen != 8'd0) begin
            nextState = ST_TX_LOAD;
          end else if (cmdRxLen != 8'd0) begin
            nextState     = ST_RX_WAIT;
            waitLoad      = 1'b1;
            waitLoadValue = waitCycles;
          end else begin
            nextState = ST_DONE;
          end
        end
      end
      ST_TX_LOAD: begin
        if (txFire) nextState = ST_TX_RUN;
      end
      ST_TX_RUN: begin
        if (txFall) begin
          nextState = ST_TX_GUARD;
          guardLoad = 1'b1;
        end
      end
      ST_TX_GUARD: begin
        if (guardZero) begin
          if (txLeft != 8'd0) begin
            nextState = ST_TX_LOAD;
          end else if (rxLeft != 8'd0) begin
            nextState = ST_RX_WAIT;
            waitLoad  = 1'b1;
          end else begin
            nextState = ST_DONE;
          end
        end
      end
      ST_RX_WAIT: begin
        if (rxEvent) begin
          nextState = ST_RX_ACK;
        end else if (uartRxStart) begin
          waitLoad = 1'b1;
        end else if (waitZero) begin
          nextState = ST_DONE;
        end
      end
      ST_RX_ACK: begin
        if (rxLeft <= 8'd1) begin
          nextState = ST_DONE;
        end else begin
          nextState = ST_RX_WAIT;
          waitLoad  = 1'b1;
        end
      end
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      txLeft       <= 8'd0;
      rxLeft       <= 8'd0;
      guardLatched <= '0;
      waitLatched  <= '0;
      txDataReg    <= 8'd0;
      rxByteReg    <= 8'd0;
      startTxReg   <= 1'b0;
      timeoutReg   <= 1'b0;
      charErrorReg <= 1'b0;
      txRunPrev    <= 1'b0;
    end else begin
      state      <= nextState;
      txRunPrev  <= uartTxRun;
      startTxReg <= txFire;
      if ((state == ST_IDLE) && cmdStart) begin
        txLeft       <= cmdTxLen;
        rxLeft       <= cmdRxLen;
        guardLatched <= guardCycles;
        waitLatched  <= waitCycles;
        timeoutReg   <= 1'b0;
        charErrorReg <= 1'b0;
      end
      if (txFire) begin
        txDataReg <= txByte;
        if (txLeft != 8'd0) txLeft <= txLeft - 8'd1;
      end
      if ((state == ST_RX_WAIT) && rxEvent) rxByteReg <= uartRxData;
      if (state == ST_RX_ACK) begin
        charErrorReg <= charErrorReg | uartFrameErr | uartOverrun;
        if (rxLeft != 8'd0) rxLeft <= rxLeft - 8'd1;
      end
      if (timeoutHit) timeoutReg <= 1'b1;
    end
  end

  iso7816_down_counter #(.WIDTH(GUARD_WIDTH)) guardCounter (
    .clk       (clk),
    .reset     (reset),
    .load      (guardLoad),
    .loadValue (guardLatched),
    .enable    (state == ST_TX_GUARD),
    .count     (guardCount),
    .zero      (guardZero)
  );

  iso7816_down_counter #(.WIDTH(WT_WIDTH)) waitCounter (
    .clk       (clk),
    .reset     (reset),
    .load      (waitLoad),
    .loadValue (waitLoadValue),
    .enable    (state == ST_RX_WAIT),
    .count     (waitCount),
    .zero      (waitZero)
  );

  // status outputs decode straight from the state register so reset clears them at once
  assign busy         = (state != ST_IDLE) && (state != ST_DONE);
  assign done         = (state == ST_DONE);
  assign rxByteValid  = (state == ST_RX_ACK);
  assign uartAckFlags = (state == ST_RX_ACK);
  assign txByteReady  = txFire;
  assign rxByte       = rxByteReg;
  assign uartTxData   = txDataReg;
  assign uartStartTx  = startTxReg;
  assign timeout      = timeoutReg;
  assign charError    = charErrorReg;

endmodule

// File: tb/tb_iso7816_exchange_sequencer.sv
// Table-driven and randomized bench for the exchange sequencer, with a behavioural UART model.
module tb_iso7816_exchange_sequencer;

  localparam int WT_W      = 24;
  localparam int GD_W      = 16;
  localparam int TX_CHAR   = 10;
  localparam int RX_START  = 8;
  localparam int CYC_LIMIT = 20000;

  typedef struct {
    int          txLen, rxLen, guard, waitC, validGap, replyDelay, noReplyAt;
    logic [63:0] txBytes, rxBytes;
    logic [7:0]  errMask;
    bit          restartMid, fullNoise;
    int          expRx;
    bit          expTimeout, expCharError;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  logic cmdStart = 1'b0;
  logic [7:0] cmdTxLen = 8'd0, cmdRxLen = 8'd0;
  logic [GD_W-1:0] guardCycles = '0;
  logic [WT_W-1:0] waitCycles = '0;
  logic [7:0] txByte = 8'd0;
  logic txByteValid = 1'b0, txByteReady;
  logic [7:0] rxByte;
  logic rxByteValid, busy, done, timeout, charError;
  logic [7:0] uartTxData;
  logic uartStartTx, uartAckFlags;
  logic uartTxRun = 1'b0, uartTxFull = 1'b0;
  logic [7:0] uartRxData = 8'd0;
  logic uartRxReady = 1'b0, uartFrameErr = 1'b0, uartOverrun = 1'b0, uartRxStart = 1'b0;

  iso7816_exchange_sequencer #(.WT_WIDTH(WT_W), .GUARD_WIDTH(GD_W)) dut (
    .clk(clk), .reset(reset), .cmdStart(cmdStart), .cmdTxLen(cmdTxLen), .cmdRxLen(cmdRxLen),
    .guardCycles(guardCycles), .waitCycles(waitCycles), .txByte(txByte), .txByteValid(txByteValid),
    .txByteReady(txByteReady), .rxByte(rxByte), .rxByteValid(rxByteValid), .busy(busy), .done(done),
    .timeout(timeout), .charError(charError), .uartTxData(uartTxData), .uartStartTx(uartStartTx),
    .uartAckFlags(uartAckFlags), .uartTxRun(uartTxRun), .uartTxFull(uartTxFull),
    .uartRxData(uartRxData), .uartRxReady(uartRxReady), .uartFrameErr(uartFrameErr),
    .uartOverrun(uartOverrun), .uartRxStart(uartRxStart)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, rowIdx = 0;

  task automatic check(input string what, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0d expected %0d", rowIdx, what, act, exp);
    end
  endtask

  task automatic checkRange(input string what, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL row %0d %s: got %0d expected %0d..%0d", rowIdx, what, act, lo, hi);
    end
  endtask

  function automatic vec_t mkRow(int tx, int rx, int g, int w, int gap, int d, int nr,
                                 logic [63:0] txb, logic [63:0] rxb, logic [7:0] em,
                                 bit restart, int eRx, bit eTo, bit eCe);
    vec_t v;
    v.txLen = tx; v.rxLen = rx; v.guard = g; v.waitC = w; v.validGap = gap;
    v.replyDelay = d; v.noReplyAt = nr; v.txBytes = txb; v.rxBytes = rxb; v.errMask = em;
    v.restartMid = restart; v.fullNoise = 1'b0;
    v.expRx = eRx; v.expTimeout = eTo; v.expCharError = eCe;
    return v;
  endfunction

  // Exchange outcome from the rules: chars are received in order until one never arrives;
  // a missing char means a timeout, and any received char flagged in error sets charError.
  function automatic vec_t refModel(vec_t v);
    vec_t r = v;
    r.expTimeout   = (v.noReplyAt < v.rxLen);
    r.expRx        = r.expTimeout ? v.noReplyAt : v.rxLen;
    r.expCharError = 1'b0;
    for (int i = 0; i < r.expRx; i++) if (v.errMask[i]) r.expCharError = 1'b1;
    return r;
  endfunction

  task automatic runRow(input vec_t v);
    int txSent = 0, gapCnt = 0, txRunCnt = 0, lastFall = 0, nextRxStart = -1, rxStartCnt = 0;
    int rxIdx = 0, rxGot = 0, ackCnt = 0, validCnt = 0, startCyc = 0, doneCyc = 0;
    bit pendingClear = 0, finished = 0, prevFull = 0, prevValid = 0;
    logic sStart, sAck, sValid, sDone, sBusy, sTimeout = 0, sCharErr = 0;
    logic [7:0] sData, sRx;
    @(negedge clk);
    cmdTxLen = 8'(v.txLen); cmdRxLen = 8'(v.rxLen);
    guardCycles = GD_W'(v.guard); waitCycles = WT_W'(v.waitC);
    cmdStart = 1'b1;
    txByte = v.txBytes[7:0]; txByteValid = (v.txLen > 0);
    startCyc = cyc;
    if (v.txLen == 0 && v.rxLen > 0 && v.noReplyAt > 0) nextRxStart = cyc + v.replyDelay;
    for (int n = 0; n < CYC_LIMIT && !finished; n++) begin
      prevFull = uartTxFull; prevValid = txByteValid;
      @(negedge clk);
      cmdStart = 1'b0;
      sStart = uartStartTx; sData = uartTxData; sAck = uartAckFlags; sValid = rxByteValid;
      sRx = rxByte; sDone = done; sBusy = busy;
      if (pendingClear) begin uartRxReady = 1'b0; uartFrameErr = 1'b0; pendingClear = 0; end
      if (v.restartMid && n == 5) begin cmdStart = 1'b1; cmdTxLen = 8'd7; cmdRxLen = 8'd7; end
      if (n == 0 && (v.txLen + v.rxLen) > 0) check("busy after start", sBusy, 1);
      // transmit side of the UART model
      if (sStart) begin
        check("startTx needs txByteValid", prevValid, 1);
        check("startTx while txFull", prevFull, 0);
        check("tx byte", sData, v.txBytes[8*(txSent%8) +: 8]);
        if (txSent > 0)
          checkRange("guard gap", cyc - lastFall, v.guard,
                     (v.validGap == 0 && !v.fullNoise) ? v.guard + 8 : CYC_LIMIT);
        txSent++;
        uartTxRun = 1'b1; txRunCnt = TX_CHAR;
        if (txSent < v.txLen) begin
          if (v.validGap > 0) begin
            txByteValid = 1'b0; txByte = ~v.txBytes[8*(txSent%8) +: 8]; gapCnt = v.validGap;
          end else begin
            txByteValid = 1'b1; txByte = v.txBytes[8*(txSent%8) +: 8];
          end
        end else begin
          txByteValid = 1'b0;
        end
      end else begin
        if (uartTxRun) begin
          txRunCnt--;
          if (txRunCnt == 0) begin
            uartTxRun = 1'b0; lastFall = cyc;
            if (txSent >= v.txLen && v.rxLen > 0 && v.noReplyAt > 0) begin
              nextRxStart = cyc + v.replyDelay; rxIdx = 0;
            end
          end
        end
        if (gapCnt > 0) begin
          gapCnt--;
          if (gapCnt == 0) begin txByte = v.txBytes[8*(txSent%8) +: 8]; txByteValid = 1'b1; end
        end
      end
      if (v.fullNoise) uartTxFull = ($urandom_range(0, 2) == 0);
      // receive side of the UART model
      if (sValid) validCnt++;
      if (sAck) begin
        ackCnt++;
        check("rx byte", sRx, v.rxBytes[8*(rxGot%8) +: 8]);
        check("rxByteValid with ack", sValid, 1);
        rxGot++; pendingClear = 1;
        if (rxGot < v.rxLen && rxGot < v.noReplyAt) begin
          nextRxStart = cyc + v.replyDelay; rxIdx = rxGot;
        end
      end
      if (nextRxStart >= 0 && cyc == nextRxStart) begin
        uartRxStart = 1'b1; rxStartCnt = RX_START; nextRxStart = -1;
      end else if (rxStartCnt > 0) begin
        rxStartCnt--;
        if (rxStartCnt == 0) begin
          uartRxStart = 1'b0;
          uartRxData = v.rxBytes[8*(rxIdx%8) +: 8];
          if (v.errMask[rxIdx%8]) uartFrameErr = 1'b1;
          else uartRxReady = 1'b1;
        end
      end
      if (sDone) begin
        finished = 1; doneCyc = cyc; sTimeout = timeout; sCharErr = charError;
        check("busy low with done", sBusy, 0);
      end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL row %0d done never seen within %0d cycles", rowIdx, CYC_LIMIT);
    end else begin
      check("timeout", sTimeout, v.expTimeout);
      check("charError", sCharErr, v.expCharError);
      if (v.txLen == 0 && v.rxLen > 0 && v.noReplyAt == 0)
        checkRange("done latency", doneCyc - startCyc, v.waitC + 1, v.waitC + 3);
    end
    check("startTx count", txSent, v.txLen);
    check("ack count", ackCnt, v.expRx);
    check("rxByteValid count", validCnt, v.expRx);
    txByteValid = 1'b0; uartTxFull = 1'b0; uartTxRun = 1'b0;
    uartRxStart = 1'b0; uartRxReady = 1'b0; uartFrameErr = 1'b0;
    $display("row %0d tx=%0d rx=%0d got=%0d timeout=%0b charError=%0b cycles=%0d",
             rowIdx, v.txLen, v.rxLen, rxGot, sTimeout, sCharErr, doneCyc - startCyc);
    repeat (2) @(negedge clk);
    rowIdx++;
  endtask

  vec_t rows[$];

  initial begin
    vec_t v;
    //                 tx rx  g    w   gap   d   nr  txBytes                 rxBytes   err    rst eRx eTo eCe
    rows.push_back(mkRow(3, 0, 20, 100, 0,    0,  8, 64'h0000_0000_00FF_3CA5, 64'h0,   8'h00, 0,  0,  0,  0));
    rows.push_back(mkRow(5, 2, 4, 1000, 0,  300,  8, 64'h0000_0011_2233_4455, 64'h9060, 8'h00, 1,  2,  0,  0));
    rows.push_back(mkRow(0, 1, 0,   50, 0,    0,  0, 64'h0,                   64'h0,   8'h00, 0,  0,  1,  0));
    rows.push_back(mkRow(1, 2, 2,  200, 0,   30,  8, 64'h0000_0000_0000_0077, 64'hC3B2, 8'h02, 0,  2,  0,  1));
    rows.push_back(mkRow(3, 0, 5,   10, 100,  0,  8, 64'h0000_0000_0012_3456, 64'h0,   8'h00, 0,  0,  0,  0));
    rows.push_back(mkRow(0, 0, 0,   10, 0,    0,  8, 64'h0,                   64'h0,   8'h00, 0,  0,  0,  0));
    rows.push_back(mkRow(0, 2, 0,    0, 0,    0,  0, 64'h0,                   64'h0,   8'h00, 0,  0,  1,  0));
    rows.push_back(mkRow(2, 3, 0,   60, 0,   10,  1, 64'h0000_0000_0000_8001, 64'h5A4B3C, 8'h01, 0, 1, 1,  1));
    rows.push_back(mkRow(4, 1, 0,   40, 0,    5,  8, 64'h0000_0000_DEAD_BEEF, 64'hE7,  8'h00, 0,  1,  0,  0));
    for (int i = 0; i < 10; i++) begin
      v.txLen = $urandom_range(0, 4); v.rxLen = $urandom_range(0, 4);
      v.guard = $urandom_range(0, 30); v.waitC = $urandom_range(20, 150);
      v.validGap = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
      v.replyDelay = $urandom_range(1, v.waitC / 2);
      v.noReplyAt = (v.rxLen > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, v.rxLen - 1) : 8;
      v.txBytes = {$urandom, $urandom}; v.rxBytes = {$urandom, $urandom};
      v.errMask = 8'($urandom); v.restartMid = 1'b0; v.fullNoise = 1'b1;
      rows.push_back(refModel(v));
    end

    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset timeout", timeout, 0);
    check("reset charError", charError, 0);
    check("reset startTx", uartStartTx, 0);
    check("reset ackFlags", uartAckFlags, 0);
    check("reset rxByteValid", rxByteValid, 0);
    check("reset txByteReady", txByteReady, 0);
    check("reset uartTxData", uartTxData, 0);
    check("reset rxByte", rxByte, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (rows[i]) runRow(rows[i]);

    // reset while waiting for a reply: outputs must drop without waiting for a clock edge
    @(negedge clk);
    cmdTxLen = 8'd0; cmdRxLen = 8'd1; guardCycles = '0; waitCycles = WT_W'(1000); cmdStart = 1'b1;
    @(negedge clk);
    cmdStart = 1'b0;
    repeat (10) @(negedge clk);
    check("busy in rx wait", busy, 1);
    reset = 1'b1;
    #1;
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    check("async reset startTx", uartStartTx, 0);
    check("async reset ackFlags", uartAckFlags, 0);
    check("async reset rxByteValid", rxByteValid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    runRow(mkRow(2, 1, 3, 80, 0, 12, 8, 64'h0000_0000_0000_6655, 64'h44, 8'h00, 0, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
